// File: rtl/parallax_layer_engine.sv
// rtl/parallax_layer_engine.sv - N-layer LFSR skyline generator composited front-to-back over sky
// Each layer scrolls its own building row; one registered 9-bit pixel per clock.
module parallax_layer_engine #(
  parameter int LAYERS   = 4,
  parameter int LFSR_W   = 9,
  parameter int TAP      = 4,
  parameter int HEIGHT_W = 4,
  parameter int COL_LOG2 = 3,
  parameter int ROW_LOG2 = 4,
  parameter int TOP0     = 112,
  parameter int TOP_STEP = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic                        visible,
  input  logic                        pause,
  input  logic [(LAYERS+1)*9-1:0]     palette,
  output logic [8:0]                  rgb,
  output logic [$clog2(LAYERS+1)-1:0] layer_id,
  output logic                        pix_valid
);
  localparam int ID_W = $clog2(LAYERS + 1);

  logic [9:0]        line_idx;
  logic [LAYERS-1:0] hit;
  logic [ID_W-1:0]   winner;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[TAP]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_idx <= '0;
    end else if (frame_start) begin
      line_idx <= '0;
    end else if (line_start && line_idx != 10'd1023) begin
      line_idx <= line_idx + 10'd1;
    end
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    localparam int PW        = COL_LOG2 - k;
    localparam int PR        = (PW > 0) ? PW : 1;
    localparam int FW        = (k > 0) ? k : 1;
    localparam int TOP       = TOP0 + k * TOP_STEP;
    localparam int UNIT_LOG2 = ROW_LOG2 - k;
    localparam logic [LFSR_W-1:0] SEED    = {LFSR_W{1'b1}} ^ LFSR_W'(k);
    localparam logic [HEIGHT_W:0] CUT_MAX = {1'b1, {HEIGHT_W{1'b0}}};

    logic [LFSR_W-1:0] lfsr, lfsr_b;
    logic [PR-1:0]     phase, phase_b;
    logic [FW-1:0]     fdiv;
    logic [HEIGHT_W:0] cutoff;
    logic [9:0]        rel;
    logic              phase_full, phase_b_full, fdiv_full, row_edge;

    // A zero-width phase means a 1 px column: the LFSR steps every pixel.
    assign phase_full   = (PW == 0) || (phase == '1);
    assign phase_b_full = (PW == 0) || (phase_b == '1);
    assign fdiv_full    = (k == 0) || (fdiv == '1);
    assign rel          = line_idx - 10'(TOP);
    assign row_edge     = (line_idx >= 10'(TOP)) && ((rel & 10'((1 << UNIT_LOG2) - 1)) == 10'd0);
    assign hit[k]       = {1'b0, lfsr[HEIGHT_W-1:0]} < cutoff;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lfsr    <= SEED;
        lfsr_b  <= SEED;
        phase   <= '0;
        phase_b <= '0;
        fdiv    <= '0;
        cutoff  <= '0;
      end else begin
        if (line_start) begin
          lfsr  <= lfsr_b;
          phase <= phase_b;
        end else if (visible) begin
          phase <= phase + 1'b1;
          if (phase_full) lfsr <= lfsr_step(lfsr);
        end

        if (frame_start) begin
          cutoff <= '0;
        end else if (line_start && row_edge && cutoff != CUT_MAX) begin
          cutoff <= cutoff + 1'b1;
        end

        // Per-frame scroll: the divider gates how often the base column advances.
        if (frame_start && !pause) begin
          fdiv <= fdiv + 1'b1;
          if (fdiv_full) begin
            phase_b <= phase_b + 1'b1;
            if (phase_b_full) lfsr_b <= lfsr_step(lfsr_b);
          end
        end
      end
    end
  end

  always_comb begin
    winner = ID_W'(LAYERS);
    for (int j = LAYERS - 1; j >= 0; j--) begin
      if (hit[j]) winner = ID_W'(j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= '0;
      layer_id  <= '0;
      pix_valid <= 1'b0;
    end else if (visible) begin
      rgb       <= palette[9*int'(winner) +: 9];
      layer_id  <= winner;
      pix_valid <= 1'b1;
    end else begin
      rgb       <= '0;
      layer_id  <= '0;
      pix_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_parallax_layer_engine.sv
// tb/tb_parallax_layer_engine.sv - scoreboard bench for parallax_layer_engine
// Expected pixels come from a behavioural layer model; strobe-level state is checked directly.
module tb_parallax_layer_engine;
  localparam int LAYERS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        visible = 1'b0;
  logic        pause = 1'b0;
  logic [44:0] palette = {9'h0DB, 9'h124, 9'h007, 9'h038, 9'h1C0};
  logic [8:0]  rgb;
  logic [2:0]  layer_id;
  logic        pix_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] sb[$];
  logic [12:0] exp_v;

  int m_lfsr[LAYERS], m_phase[LAYERS], m_lfsr_b[LAYERS], m_phase_b[LAYERS];
  int m_fdiv[LAYERS], m_cut[LAYERS];
  int m_line;

  parallax_layer_engine dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .visible(visible), .pause(pause), .palette(palette),
    .rgb(rgb), .layer_id(layer_id), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lstep(input int v);
    return ((v << 1) & 'h1FF) | (((v >> 8) ^ (v >> 4)) & 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LAYERS; k++) begin
      m_lfsr[k] = 'h1FF ^ k;  m_lfsr_b[k] = 'h1FF ^ k;
      m_phase[k] = 0; m_phase_b[k] = 0; m_fdiv[k] = 0; m_cut[k] = 0;
    end
    m_line = 0;
  endtask

  function automatic logic [12:0] model_out(input bit vis);
    int win = LAYERS;
    for (int k = LAYERS - 1; k >= 0; k--)
      if ((m_lfsr[k] & 15) < m_cut[k]) win = k;
    if (!vis) return 13'd0;
    return {palette[9*win +: 9], 3'(win), 1'b1};
  endfunction

  task automatic model_step(input bit fs, input bit ls, input bit vis, input bit pau);
    for (int k = 0; k < LAYERS; k++) begin
      int pmax = (1 << (3 - k)) - 1;
      int top = 112 + 64 * k;
      int unit = 1 << (4 - k);
      bit full;
      if (ls) begin
        m_lfsr[k] = m_lfsr_b[k];
        m_phase[k] = m_phase_b[k];
      end else if (vis) begin
        if (m_phase[k] == pmax) m_lfsr[k] = lstep(m_lfsr[k]);
        m_phase[k] = (m_phase[k] + 1) & pmax;
      end
      if (fs) m_cut[k] = 0;
      else if (ls && m_line >= top && ((m_line - top) % unit) == 0 && m_cut[k] < 16) m_cut[k]++;
      if (fs && !pau) begin
        full = (k == 0) || (m_fdiv[k] == (1 << k) - 1);
        m_fdiv[k] = (k == 0) ? 0 : (m_fdiv[k] + 1) % (1 << k);
        if (full) begin
          if (m_phase_b[k] == pmax) m_lfsr_b[k] = lstep(m_lfsr_b[k]);
          m_phase_b[k] = (m_phase_b[k] + 1) & pmax;
        end
      end
    end
    if (fs) m_line = 0;
    else if (ls && m_line < 1023) m_line++;
  endtask

  task automatic drive(input bit fs, input bit ls, input bit vis, input bit pau);
    frame_start = fs; line_start = ls; visible = vis; pause = pau;
    sb.push_back(model_out(vis));
    model_step(fs, ls, vis, pau);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if ({rgb, layer_id, pix_valid} !== 13'd0) begin n_err++; $display("FAIL reset_out: got %h want 0", {rgb, layer_id, pix_valid}); end
    n_cmp++; if (dut.g_layer[0].lfsr !== 9'h1FF) begin n_err++; $display("FAIL reset_lfsr0: got %h want 1ff", dut.g_layer[0].lfsr); end
    n_cmp++; if (dut.line_idx !== 10'd0) begin n_err++; $display("FAIL reset_line_idx: got %0d want 0", dut.line_idx); end
    rst = 1'b0;
    model_reset();
    drive(0, 1, 0, 0);
    exp_v = sb.pop_front();
    n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL reset_ls: got %h want %h", {rgb, layer_id, pix_valid}, exp_v); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL reset_pix %0d: got %h want %h", i, {rgb, layer_id, pix_valid}, exp_v); end
    end
    // Assert mid-line with visible high; outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rgb !== 9'd0) begin n_err++; $display("FAIL async_rgb: got %h want 0", rgb); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", pix_valid); end
    n_cmp++; if (layer_id !== 3'd0) begin n_err++; $display("FAIL async_id: got %0d want 0", layer_id); end
    n_cmp++; if (dut.g_layer[0].lfsr !== 9'h1FF) begin n_err++; $display("FAIL async_lfsr0: got %h want 1ff", dut.g_layer[0].lfsr); end
    n_cmp++; if (dut.g_layer[1].lfsr !== 9'h1FE) begin n_err++; $display("FAIL async_lfsr1: got %h want 1fe", dut.g_layer[1].lfsr); end
    visible = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_column_width();
    drive(0, 1, 0, 0);
    exp_v = sb.pop_front();
    n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL col_ls: got %h want %h", {rgb, layer_id, pix_valid}, exp_v); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL col_pix %0d: got %h want %h", i, {rgb, layer_id, pix_valid}, exp_v); end
    end
    n_cmp++; if (dut.g_layer[0].lfsr !== 9'h1FC) begin n_err++; $display("FAIL col_lfsr0: got %h want 1fc", dut.g_layer[0].lfsr); end
    n_cmp++; if (dut.g_layer[1].lfsr !== 9'h1E0) begin n_err++; $display("FAIL col_lfsr1: got %h want 1e0", dut.g_layer[1].lfsr); end
  endtask

  task automatic test_scroll();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, 0, 0, p[0]);
        exp_v = sb.pop_front();
        n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL scroll_fs: got %h want %h", {rgb, layer_id, pix_valid}, exp_v); end
      end
      n_cmp++; if (dut.g_layer[0].phase_b !== 3'd4) begin n_err++; $display("FAIL scroll_phase_b0 pause=%0d: got %0d want 4", p, dut.g_layer[0].phase_b); end
      n_cmp++; if (dut.g_layer[1].phase_b !== 2'd2) begin n_err++; $display("FAIL scroll_phase_b1 pause=%0d: got %0d want 2", p, dut.g_layer[1].phase_b); end
    end
  endtask

  task automatic test_sky_only();
    drive(1, 0, 0, 0);
    exp_v = sb.pop_front();
    n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL sky_fs: got %h want %h", {rgb, layer_id, pix_valid}, exp_v); end
    for (int l = 0; l < 112; l++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL sky_ls %0d: got %h want %h", l, {rgb, layer_id, pix_valid}, exp_v); end
      for (int i = 0; i < 16; i++) begin
        drive(0, 0, 1, 0);
        exp_v = sb.pop_front();
        n_cmp++; if ({rgb, layer_id, pix_valid} !== {9'h0DB, 3'd4, 1'b1}) begin n_err++; $display("FAIL sky_pix line %0d: got %h want %h", l, {rgb, layer_id, pix_valid}, {9'h0DB, 3'd4, 1'b1}); end
      end
      drive(0, 0, 0, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL sky_blank %0d: got %h want %h", l, {rgb, layer_id, pix_valid}, exp_v); end
    end
  endtask

  task automatic test_staircase();
    for (int l = 112; l < 400; l++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL stair_ls %0d: got %h want %h", l, {rgb, layer_id, pix_valid}, exp_v); end
      if (l == 128) begin
        n_cmp++; if (dut.g_layer[0].cutoff !== 5'd2) begin n_err++; $display("FAIL stair_cut128: got %0d want 2", dut.g_layer[0].cutoff); end
      end
      if (l == 352) begin
        n_cmp++; if (dut.g_layer[0].cutoff !== 5'd16) begin n_err++; $display("FAIL stair_cut352: got %0d want 16", dut.g_layer[0].cutoff); end
      end
      for (int i = 0; i < 16; i++) begin
        drive(0, 0, 1, 0);
        exp_v = sb.pop_front();
        n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL stair_pix line %0d px %0d: got %h want %h", l, i, {rgb, layer_id, pix_valid}, exp_v); end
        if (l >= 352) begin
          n_cmp++; if (layer_id !== 3'd0) begin n_err++; $display("FAIL stair_solid line %0d: got %0d want 0", l, layer_id); end
        end
      end
      drive(0, 0, 0, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL stair_blank %0d: got %h want %h", l, {rgb, layer_id, pix_valid}, exp_v); end
    end
  endtask

  task automatic test_coincident();
    int old_b[LAYERS];
    for (int k = 0; k < LAYERS; k++) old_b[k] = m_lfsr_b[k];
    drive(1, 1, 0, 0);
    exp_v = sb.pop_front();
    n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL coinc_out: got %h want %h", {rgb, layer_id, pix_valid}, exp_v); end
    n_cmp++; if (dut.line_idx !== 10'd0) begin n_err++; $display("FAIL coinc_line_idx: got %0d want 0", dut.line_idx); end
    n_cmp++; if (dut.g_layer[0].cutoff !== 5'd0) begin n_err++; $display("FAIL coinc_cut0: got %0d want 0", dut.g_layer[0].cutoff); end
    n_cmp++; if (dut.g_layer[3].cutoff !== 5'd0) begin n_err++; $display("FAIL coinc_cut3: got %0d want 0", dut.g_layer[3].cutoff); end
    n_cmp++; if (dut.g_layer[0].lfsr !== 9'(old_b[0])) begin n_err++; $display("FAIL coinc_lfsr0: got %h want %h", dut.g_layer[0].lfsr, old_b[0]); end
    n_cmp++; if (dut.g_layer[1].lfsr !== 9'(old_b[1])) begin n_err++; $display("FAIL coinc_lfsr1: got %h want %h", dut.g_layer[1].lfsr, old_b[1]); end
  endtask

  task automatic test_back_to_back();
    // Back-to-back line strobes drive line_idx into saturation and every layer solid.
    for (int i = 0; i < 1030; i++) begin
      drive(0, 1, 0, 0);
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL b2b_ls %0d: got %h want %h", i, {rgb, layer_id, pix_valid}, exp_v); end
    end
    n_cmp++; if (dut.line_idx !== 10'd1023) begin n_err++; $display("FAIL b2b_sat: got %0d want 1023", dut.line_idx); end
    n_cmp++; if (dut.g_layer[3].cutoff !== 5'd16) begin n_err++; $display("FAIL b2b_cut3: got %0d want 16", dut.g_layer[3].cutoff); end
    drive(0, 0, 1, 0);
    exp_v = sb.pop_front();
    n_cmp++; if ({rgb, layer_id, pix_valid} !== {9'h1C0, 3'd0, 1'b1}) begin n_err++; $display("FAIL b2b_solid: got %h want %h", {rgb, layer_id, pix_valid}, {9'h1C0, 3'd0, 1'b1}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) palette = 45'({$urandom(), $urandom()});
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = sb.pop_front();
      n_cmp++; if ({rgb, layer_id, pix_valid} !== exp_v) begin n_err++; $display("FAIL rand %0d: got %h want %h", i, {rgb, layer_id, pix_valid}, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_column_width();
    test_scroll();
    test_sky_only();
    test_staircase();
    test_coincident();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/parallax_layer_engine.md
# parallax_layer_engine

Parametrised N-layer parallax skyline generator for the VGA scroller. It takes line/frame strobes and a visibility flag from the sync generator and produces one 9-bit RGB pixel per clock. Each layer is an LFSR-driven building row with its own column width, scroll rate and vertical extent, composited front-to-back over a sky colour. The output feeds the colour ditherer.

## Interface
- `LAYERS`, 4: number of building layers, 1..8; layer 0 is frontmost.
- `LFSR_W`, 9: LFSR width per layer.
- `TAP`, 4: second feedback tap; feedback = `lfsr[LFSR_W-1] ^ lfsr[TAP]`.
- `HEIGHT_W`, 4: height bits taken from `lfsr[HEIGHT_W-1:0]`; `HEIGHT_W <= LFSR_W`.
- `COL_LOG2`, 3: layer k column width = 2^(COL_LOG2-k) px; `COL_LOG2 >= LAYERS-1`.
- `ROW_LOG2`, 4: layer k height unit = 2^(ROW_LOG2-k) lines; `ROW_LOG2 >= LAYERS-1`.
- `TOP0`, 112 / `TOP_STEP`, 64: layer k top line = TOP0 + k*TOP_STEP.
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse per frame, in vertical blanking.
- `line_start` in 1: one-cycle pulse per line, in horizontal blanking.
- `visible` in 1: current cycle is an active pixel.
- `pause` in 1: freezes scroll advance; sampled at `frame_start`.
- `palette` in (LAYERS+1)*9: entry j at bits [9j+8:9j], {r3,g3,b3}; entry LAYERS = sky.
- `rgb` out 9: registered pixel colour.
- `layer_id` out clog2(LAYERS+1): registered winning layer index, LAYERS = sky.
- `pix_valid` out 1: registered `visible`.

## Operation
- Per layer k: running `lfsr_k`, `phase_k` (COL_LOG2-k bits); frame bases `lfsr_b_k`, `phase_b_k`; frame divider `fdiv_k` (k bits, absent for k=0); `cutoff_k` (HEIGHT_W+1 bits). Shared: `line_idx` (10 bits, saturating at 1023).
- Seed: SEED_k = all-ones ^ k; reset loads `lfsr_k`, `lfsr_b_k` with SEED_k; all other state and all outputs reset to 0.
- LFSR step: shift left one bit, bit 0 = feedback.
- Visible cycle: `phase_k` increments (wraps); when `phase_k` is all-ones, `lfsr_k` steps.
- `line_start`: `lfsr_k <= lfsr_b_k`, `phase_k <= phase_b_k` (overrides a simultaneous visible step). If `line_idx >= top_k` and (`line_idx - top_k`) is a multiple of 2^(ROW_LOG2-k), `cutoff_k` increments, saturating at 2^HEIGHT_W. Then `line_idx` increments.
- `frame_start`: `line_idx <= 0`, all `cutoff_k <= 0`. If `pause` is 0: `fdiv_k` increments. When `fdiv_k` is all-ones (always true for k=0), `phase_b_k` increments. When `phase_b_k` is also all-ones, `lfsr_b_k` steps. With `pause`=1, all dividers and bases hold.
- Simultaneous `frame_start` and `line_start`: the `frame_start` updates to `line_idx` and `cutoff` win. `lfsr_k`/`phase_k` load the pre-update base values.
- Composite: layer k hits when `lfsr_k[HEIGHT_W-1:0] < cutoff_k`. The lowest hitting k wins; with no hit the result is sky (LAYERS).
- When `cutoff_k` = 2^HEIGHT_W, layer k is solid.

## Timing
- Latency 1 cycle: on the edge after a cycle with `visible`=1, `rgb` = palette[winner], `layer_id` = winner, `pix_valid` = 1.
- On the edge after a cycle with `visible`=0: `rgb`=0, `layer_id`=0, `pix_valid`=0.
- The composite uses the `lfsr_k`/`cutoff_k` values held before the current edge's updates.
- Reset is asynchronous. Assertion mid-line or mid-frame immediately returns all state to reset values. The first `frame_start` after release restarts cleanly.
- `palette` is sampled combinationally into the output register; changes take effect on the next pixel.

## Test plan
- Reset mid-line: pulse `rst` while `visible`=1 -> `rgb`=0, `pix_valid`=0 and `lfsr_0`=0x1FF immediately, without waiting for a clock edge.
- Sky only: LAYERS=4, lines 0..111 -> every pixel has `layer_id`=4 and `rgb`=palette[4].
- Cutoff staircase: line with `line_idx`=128 -> `cutoff_0`=2, so layer 0 hits only where `lfsr_0[3:0]` is 0 or 1. Solid from `line_idx`=352, where `cutoff_0`=16.
- Column width: 16 visible cycles after `line_start` -> `lfsr_0` steps exactly twice (every 8 px) and `lfsr_1` exactly 4 times (every 4 px).
- Scroll rate: 4 `frame_start` pulses with `pause`=0 -> `phase_b_0`=4, `phase_b_1`=2. With `pause`=1 -> both unchanged.
- Coincident strobes: `frame_start` and `line_start` on the same cycle -> `line_idx`=0, cutoffs 0, `lfsr_k` = old `lfsr_b_k`.
